// File: rtl/uart_pkg.sv
// Shared constants, character helper and FSM encoding for the result printer.
package uart_pkg;

  localparam logic [7:0] ASCII_CR          = 8'h0D;
  localparam logic [7:0] ASCII_LF          = 8'h0A;
  localparam logic [7:0] ASCII_DIGIT_BASE  = 8'h30;
  localparam logic [7:0] ASCII_LETTER_BASE = 8'h41;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_e;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_DIGIT_BASE + {4'h0, nib};
    else             return ASCII_LETTER_BASE + {4'h0, nib - 4'd10};
  endfunction

endpackage

// File: rtl/uart_result_printer_if.sv
// Producer-side request/status handshake of the result printer.
interface uart_result_printer_if #(
  parameter int DIGITS = 4
);
  logic                  ready_in;
  logic [4*DIGITS-1:0]   data_in;
  logic                  error_in;
  logic                  busy;
  logic                  done;

  modport master (output ready_in, data_in, error_in, input busy, done);
  modport slave  (input ready_in, data_in, error_in, output busy, done);
endinterface

// File: rtl/uart_result_printer_byte_tx.sv
// 8N1 byte serializer; tx_busy drops during the last stop-bit cycle so a
// queued byte can begin right as the stop bit ends.
module uart_byte_tx #(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx
);

  localparam int BIT_PERIOD = CLOCK_RATE / BAUD_RATE;
  localparam int TMR_W      = (BIT_PERIOD < 2) ? 1 : $clog2(BIT_PERIOD);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(BIT_PERIOD - 1);

  if (BIT_PERIOD < 2) begin : g_bad_period
    $error("uart_byte_tx: CLOCK_RATE/BAUD_RATE must be at least 2");
  end

  logic             busy_q;
  logic             pend_q;
  logic             tx_q;
  logic [9:0]       frame_q;
  logic [3:0]       bits_left_q;
  logic [TMR_W-1:0] tmr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      tx_q        <= 1'b1;
      frame_q     <= '1;
      bits_left_q <= '0;
      tmr_q       <= '0;
    end else if (pend_q) begin
      tx_q    <= frame_q[0];
      frame_q <= {1'b1, frame_q[9:1]};
      tmr_q   <= TMR_RELOAD;
      pend_q  <= 1'b0;
    end else if (busy_q) begin
      if (tmr_q == '0) begin
        tx_q        <= frame_q[0];
        frame_q     <= {1'b1, frame_q[9:1]};
        tmr_q       <= TMR_RELOAD;
        bits_left_q <= bits_left_q - 4'd1;
      end else begin
        tmr_q <= tmr_q - TMR_W'(1);
        // Release one cycle early: the pending stage keeps the stop bit full length.
        if (tmr_q == TMR_W'(1) && bits_left_q == '0) busy_q <= 1'b0;
      end
    end else if (tx_start) begin
      busy_q      <= 1'b1;
      pend_q      <= 1'b1;
      frame_q     <= {1'b1, tx_data, 1'b0};
      bits_left_q <= 4'd9;
    end
  end

  assign tx_busy = busy_q;
  assign tx      = tx_q;

endmodule

// File: rtl/uart_result_printer.sv
// Prints a captured hex result (or an error string) plus optional CR/LF as UART frames.
// state | meaning: IDLE wait accept, LOAD issue char idx, SEND wait frame, DONE pulse done
module uart_result_printer
  import uart_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CLOCK_RATE     = 100_000_000,
  parameter int BAUD_RATE      = 9600,
  parameter int MSB_FIRST      = 1,
  parameter int SEND_CRLF      = 1,
  parameter int ERROR_MSG_SIZE = 5,
  parameter logic [8*ERROR_MSG_SIZE-1:0] ERROR_MSG = "Error"
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_result_printer_if.slave   bus,
  output logic                   RsTx
);

  localparam int BODY_MAX = (DIGITS > ERROR_MSG_SIZE) ? DIGITS : ERROR_MSG_SIZE;
  localparam int CRLF_LEN = (SEND_CRLF != 0) ? 2 : 0;
  localparam int MAX_LEN  = BODY_MAX + CRLF_LEN;
  localparam int IDX_W    = $clog2(MAX_LEN + 1);

  localparam logic [IDX_W-1:0] DATA_BODY = IDX_W'(DIGITS);
  localparam logic [IDX_W-1:0] ERR_BODY  = IDX_W'(ERROR_MSG_SIZE);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DIGITS + CRLF_LEN - 1);
  localparam logic [IDX_W-1:0] ERR_LAST  = IDX_W'(ERROR_MSG_SIZE + CRLF_LEN - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] data_q;
  logic                err_q;

  logic                busy_w;
  logic                accept_w;
  logic                tx_start_w;
  logic                tx_busy_w;
  logic [7:0]          char_w;
  logic [3:0]          nib_w;
  logic [IDX_W-1:0]    body_len_w;
  logic [IDX_W-1:0]    last_idx_w;

  assign busy_w     = (state_q == ST_LOAD) || (state_q == ST_SEND);
  assign accept_w   = bus.ready_in && !busy_w;
  assign body_len_w = err_q ? ERR_BODY : DATA_BODY;
  assign last_idx_w = err_q ? ERR_LAST : DATA_LAST;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept_w) begin
        data_q <= bus.data_in;
        err_q  <= bus.error_in;
      end
    end
  end

  // Character mux: body characters, then CR at idx == body length, then LF.
  always_comb begin
    char_w = ASCII_LF;
    nib_w  = '0;
    if (idx_q < body_len_w) begin
      if (err_q) begin
        for (int i = 0; i < ERROR_MSG_SIZE; i++)
          if (idx_q == IDX_W'(i)) char_w = ERROR_MSG[8*(ERROR_MSG_SIZE-1-i) +: 8];
      end else begin
        for (int i = 0; i < DIGITS; i++)
          if (idx_q == IDX_W'(i))
            nib_w = (MSB_FIRST != 0) ? data_q[4*(DIGITS-1-i) +: 4] : data_q[4*i +: 4];
        char_w = nibble_to_ascii(nib_w);
      end
    end else if (idx_q == body_len_w) begin
      char_w = ASCII_CR;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_start_w = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept_w) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        tx_start_w = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy_w) begin
          if (idx_q == last_idx_w) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy = busy_w;
  assign bus.done = (state_q == ST_DONE);

  uart_byte_tx #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE)
  ) u_byte_tx (
    .clk      (clk),
    .reset    (reset),
    .tx_start (tx_start_w),
    .tx_data  (char_w),
    .tx_busy  (tx_busy_w),
    .tx       (RsTx)
  );

endmodule
